alu_muldiv: RTL

Parametrised multi-cycle execute unit that supersedes the single-cycle ALU. It covers all RV32I/RV64I ALU operations and adds the RV M-extension: MUL/MULH/MULHSU/MULHU through a two-stage multiplier and DIV/DIVU/REM/REMU through an iterative radix-2 divider. It sits in the EX stage behind a valid/ready handshake and tells the hazard unit to stall while a long operation is in flight. Branch comparison moves to a separate comparator and is not part of this block.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/divider_iter.sv | 60 ++++++
 rtl/alu_muldiv.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle execute unit: operation codes, FSM states
// and operation-class helpers.
package alu_pkg;

  // op[4]=1 marks M-extension operations; op[3:2] selects multiply or divide.
  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_AND    = 5'h02,
    OP_OR     = 5'h03,
    OP_XOR    = 5'h04,
    OP_SLT    = 5'h05,
    OP_SLTU   = 5'h06,
    OP_SLL    = 5'h07,
    OP_SRL    = 5'h08,
    OP_SRA    = 5'h09,
    OP_PASSB  = 5'h0A,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  function automatic logic is_mul(input logic [4:0] op);
    return op[4] && (op[3:2] == 2'b00);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op[4] && (op[3:2] == 2'b01);
  endfunction

endpackage

// File: rtl/divider_iter.sv
// Unsigned restoring divider: one quotient bit per cycle for W cycles after start.
// Operands are magnitudes; sign handling lives in the caller.
module divider_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          running;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem_q, quo_q, dsr_q;
  logic [W:0]    shifted, trial;
  logic          fits;

  // A negative trial difference shows up as bit W set, meaning "restore".
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {1'b0, dsr_q};
    fits    = ~trial[W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= dividend;
      dsr_q   <= divisor;
    end else if (running) begin
      rem_q <= fits ? trial[W-1:0] : shifted[W-1:0];
      quo_q <= {quo_q[W-2:0], fits};
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) running <= 1'b0;
    end
  end

  assign done      = running && (cnt == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage execute unit: single-cycle base ALU ops, pipelined multiply and
// iterative divide behind a valid/ready handshake with a stall (busy) output.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATAWIDTH   = 32,
  parameter int SHIFT_WIDTH = $clog2(DATAWIDTH),
  parameter int MUL_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [4:0]           op_i,
  input  logic [DATAWIDTH-1:0] SrcA_i,
  input  logic [DATAWIDTH-1:0] SrcB_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  output logic [DATAWIDTH-1:0] Result_o,
  output logic                 busy_o
);

  // Handshake: an operation is taken on a rising edge when valid_i && ready_o
  // && !flush_i; ready_o is high only in IDLE, valid_o pulses for one cycle.
  localparam int W = DATAWIDTH;
  localparam logic [1:0] MUL_LAST = 2'(MUL_STAGES - 2);

  state_t        state, state_next;
  alu_op_t       op;
  logic          accept;
  logic          valid_q, valid_next;
  logic [W-1:0]  result_q, result_next;

  assign op     = alu_op_t'(op_i);
  assign accept = valid_i && (state == IDLE) && !flush_i;

  // Base-op datapath
  logic [SHIFT_WIDTH-1:0] shamt;
  logic [W-1:0]           base_res;

  always_comb begin
    shamt = SrcB_i[SHIFT_WIDTH-1:0];
    case (op)
      OP_ADD:   base_res = SrcA_i + SrcB_i;
      OP_SUB:   base_res = SrcA_i - SrcB_i;
      OP_AND:   base_res = SrcA_i & SrcB_i;
      OP_OR:    base_res = SrcA_i | SrcB_i;
      OP_XOR:   base_res = SrcA_i ^ SrcB_i;
      OP_SLT:   base_res = {{(W-1){1'b0}}, $signed(SrcA_i) < $signed(SrcB_i)};
      OP_SLTU:  base_res = {{(W-1){1'b0}}, SrcA_i < SrcB_i};
      OP_SLL:   base_res = SrcA_i << shamt;
      OP_SRL:   base_res = SrcA_i >> shamt;
      OP_SRA:   base_res = W'($signed(SrcA_i) >>> shamt);
      OP_PASSB: base_res = SrcB_i;
      default:  base_res = '0;
    endcase
  end

  // Multiplier: extended operands are registered at accept, product registered
  // into Result_o once the configured latency has elapsed.
  logic           a_sgn, b_sgn, mul_hi, mul_hi_q;
  logic [2*W-1:0] a_ext, b_ext, mul_a_q, mul_b_q, mul_a, mul_b, product;
  logic [1:0]     mul_cnt;
  logic [W-1:0]   mul_res;

  always_comb begin
    a_sgn   = (op == OP_MULH) || (op == OP_MULHSU);
    b_sgn   = (op == OP_MULH);
    a_ext   = {{W{a_sgn & SrcA_i[W-1]}}, SrcA_i};
    b_ext   = {{W{b_sgn & SrcB_i[W-1]}}, SrcB_i};
    mul_a   = (state == IDLE) ? a_ext : mul_a_q;
    mul_b   = (state == IDLE) ? b_ext : mul_b_q;
    mul_hi  = (state == IDLE) ? (op != OP_MUL) : mul_hi_q;
    product = mul_a * mul_b;
    mul_res = mul_hi ? product[2*W-1:W] : product[W-1:0];
  end

  // Divider front end: magnitudes, sign bookkeeping and the special cases
  logic         div_sgn, div_rem, a_neg, b_neg, div_zero, div_ovf, spec_hit;
  logic [W-1:0] a_mag, b_mag, spec_val;
  logic         rem_sel_q, neg_quo_q, neg_rem_q, spec_q;
  logic [W-1:0] spec_val_q, div_quo, div_remd, fix_res;
  logic         div_start, div_done;

  always_comb begin
    div_sgn  = (op == OP_DIV) || (op == OP_REM);
    div_rem  = (op == OP_REM) || (op == OP_REMU);
    a_neg    = div_sgn & SrcA_i[W-1];
    b_neg    = div_sgn & SrcB_i[W-1];
    a_mag    = a_neg ? -SrcA_i : SrcA_i;
    b_mag    = b_neg ? -SrcB_i : SrcB_i;
    div_zero = (SrcB_i == '0);
    div_ovf  = div_sgn && (SrcA_i == {1'b1, {(W-1){1'b0}}}) && (SrcB_i == '1);
    spec_hit = div_zero || div_ovf;
    if (div_zero) spec_val = div_rem ? SrcA_i : '1;
    else          spec_val = div_rem ? '0 : SrcA_i;
    div_start = accept && is_div(op_i) && !spec_hit;
  end

  always_comb begin
    if (spec_q)         fix_res = spec_val_q;
    else if (rem_sel_q) fix_res = neg_rem_q ? -div_remd : div_remd;
    else                fix_res = neg_quo_q ? -div_quo : div_quo;
  end

  divider_iter #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush_i),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_remd)
  );

  always_comb begin
    state_next  = state;
    valid_next  = 1'b0;
    result_next = result_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul(op_i)) begin
            if (MUL_STAGES == 1) begin
              valid_next  = 1'b1;
              result_next = mul_res;
            end else begin
              state_next = MUL;
            end
          end else if (is_div(op_i)) begin
            state_next = spec_hit ? FIX : DIV;
          end else begin
            valid_next  = 1'b1;
            result_next = base_res;
          end
        end
      end
      MUL: begin
        if (mul_cnt == MUL_LAST) begin
          state_next  = IDLE;
          valid_next  = 1'b1;
          result_next = mul_res;
        end
      end
      DIV: begin
        if (div_done) state_next = FIX;
      end
      FIX: begin
        state_next  = IDLE;
        valid_next  = 1'b1;
        result_next = fix_res;
      end
      default: state_next = IDLE;
    endcase
    if (flush_i) begin
      state_next  = IDLE;
      valid_next  = 1'b0;
      result_next = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_next;
      valid_q  <= valid_next;
      result_q <= result_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_hi_q   <= 1'b0;
      mul_cnt    <= '0;
      rem_sel_q  <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
    end else if (accept) begin
      mul_a_q    <= a_ext;
      mul_b_q    <= b_ext;
      mul_hi_q   <= (op != OP_MUL);
      mul_cnt    <= '0;
      rem_sel_q  <= div_rem;
      neg_quo_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      spec_q     <= spec_hit;
      spec_val_q <= spec_val;
    end else if (state == MUL) begin
      mul_cnt <= mul_cnt + 1'b1;
    end
  end

  // A flush in the same cycle also hides a base-op result already registered.
  assign valid_o  = valid_q & ~flush_i;
  assign ready_o  = (state == IDLE);
  assign busy_o   = (state != IDLE);
  assign Result_o = result_q;

endmodule
